// File: rtl/mips_muldiv.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide, one bit per cycle.
// Signed MULT/DIV (op[0]) is built only when MIPS_MULDIV_SIGNED_EN is defined; otherwise every op is unsigned.
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  // Multiply: {upper partial sum, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

`ifdef MIPS_MULDIV_SIGNED_EN
  logic sgn_a, sgn_b;
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  assign sgn_a = op[0] & a[WIDTH-1];
  assign sgn_b = op[0] & b[WIDTH-1];
  assign a_mag = sgn_a ? -a : a;
  assign b_mag = sgn_b ? -b : b;

  // The remainder follows the dividend's sign; for a zero divisor this restores the original a in HI.
  assign prod_fix = neg_q_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (state_q == S_IDLE && start) begin
      neg_q_d = sgn_a ^ sgn_b;
      neg_r_d = sgn_a;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  logic unused_op0;

  assign unused_op0 = op[0];
  assign a_mag      = a;
  assign b_mag      = b;
  assign prod_fix   = acc_q;
  assign quo_fix    = acc_q[WIDTH-1:0];
  assign rem_fix    = acc_q[2*WIDTH-1:WIDTH];
`endif

  // One iteration of each algorithm, selected by is_div_q in RUN.
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               div_fit;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign addend   = acc_q[0] ? opnd_q : '0;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_fit  = rem_sh >= {1'b0, opnd_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_next = div_fit ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                            : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // NOTE: every next-state value defaults to its register first, so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          opnd_d   = op[1] ? b_mag : a_mag;
          cnt_d    = CNT_W'(WIDTH);
          dbz_d    = 1'b0;
          state_d  = S_RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
          if (opnd_q == '0) begin
            lo_d  = '1;
            dbz_d = 1'b1;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: vector table plus scoreboard queue, and hand-written
// sequences for moves, back-to-back issue, ignored mid-run stimulus and reset during RUN.
module tb_mips_muldiv;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
`ifdef MIPS_MULDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        op = 2'b00;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              mthi = 1'b0;
  logic              mtlo = 1'b0;
  logic [WIDTH-1:0]  wdata = '0;
  logic              busy, done, div_by_zero;
  logic [WIDTH-1:0]  hi, lo;

  mips_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
    logic        exp_dbz;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi, lo;
    logic        dbz;
  } res_t;

  res_t        sb_q[$];
  vec_t        vecs[12];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is captured at the next posedge (E0) and dropped afterwards.
  task automatic issue(input vec_t v);
    res_t r;
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    r.hi = v.exp_hi; r.lo = v.exp_lo; r.dbz = v.exp_dbz;
    sb_q.push_back(r);
    @(negedge clock);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
  endtask

  // n counts posedges after E0; done must be visible right after E33.
  task automatic wait_result(input string tag, input bit inject);
    int   n = 0;
    int   busy_n = 0;
    logic hold = 1'b1;
    res_t r;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if (hi !== hi_m || lo !== lo_m) hold = 1'b0;
      if (inject) begin
        case (n)
          10: begin start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd1; end
          11: start = 1'b0;
          12: begin mthi = 1'b1; wdata = 32'hAA; end
          13: mthi = 1'b0;
          default: ;
        endcase
      end
      @(negedge clock);
      n++;
    end
    check($sformatf("%s latency", tag), 64'(n), 64'd33);
    check($sformatf("%s busy cycles", tag), 64'(busy_n), 64'd33);
    check($sformatf("%s hold during run", tag), 64'(hold), 64'd1);
    if (!done) begin
      if (sb_q.size() > 0) sb_q.delete(0);
    end else if (sb_q.size() == 0) begin
      check($sformatf("%s unexpected done", tag), 64'(done), 64'd0);
    end else begin
      r = sb_q.pop_front();
      check($sformatf("%s hi", tag), 64'(hi), 64'(r.hi));
      check($sformatf("%s lo", tag), 64'(lo), 64'(r.lo));
      check($sformatf("%s div_by_zero", tag), 64'(div_by_zero), 64'(r.dbz));
      check($sformatf("%s busy at done", tag), 64'(busy), 64'd0);
      hi_m = r.hi;
      lo_m = r.lo;
    end
  endtask

  initial begin
    vec_t v;
    logic saw_done;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'd7, (SGN ? 32'hFFFFFFFF : 32'h6), 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'd2, (SGN ? 32'hFFFFFFFF : 32'h1),
                 (SGN ? 32'hFFFFFFFD : 32'h7FFFFFFC), 1'b0};
    vecs[3]  = '{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    vecs[4]  = '{2'b10, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, (SGN ? 32'h0 : 32'h80000000),
                 (SGN ? 32'h80000000 : 32'h0), 1'b0};
    vecs[6]  = '{2'b11, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, (SGN ? 32'h0 : 32'hFFFFFFFE), 32'h1, 1'b0};
    vecs[8]  = '{2'b11, 32'd7, 32'hFFFFFFFE, (SGN ? 32'h1 : 32'h7), (SGN ? 32'hFFFFFFFD : 32'h0), 1'b0};
    vecs[9]  = '{2'b00, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0};
    vecs[10] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0};
    vecs[11] = '{2'b00, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0};

    // Reset must act without a clock edge.
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i]);
      check($sformatf("vec%0d busy after start", i), 64'(busy), 64'd1);
      wait_result($sformatf("vec%0d", i), 1'b0);
      @(negedge clock);
    end

    // Back-to-back: new start accepted on the done cycle; done is a single-cycle pulse.
    issue('{2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0});
    wait_result("b2b first", 1'b0);
    issue('{2'b00, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0});
    check("b2b done one-shot", 64'(done), 64'd0);
    check("b2b busy", 64'(busy), 64'd1);
    wait_result("b2b second", 1'b0);
    @(negedge clock);

    // Sticky divide-by-zero flag is cleared by the next start.
    issue('{2'b10, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1});
    wait_result("dbz set", 1'b0);
    @(negedge clock);
    check("dbz sticky in idle", 64'(div_by_zero), 64'd1);
    issue('{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
    check("dbz cleared by start", 64'(div_by_zero), 64'd0);
    wait_result("dbz next", 1'b0);
    @(negedge clock);

    // Start and mthi while busy are ignored.
    issue('{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
    wait_result("midrun", 1'b1);
    mtlo = 1'b1; wdata = 32'h55;
    @(negedge clock);
    mtlo = 1'b0;
    check("mtlo lo", 64'(lo), 64'h55);
    check("mtlo hi kept", 64'(hi), 64'(hi_m));
    check("mtlo no done", 64'(done), 64'd0);
    lo_m = 32'h55;

    mthi = 1'b1; wdata = 32'hAAAA0001;
    @(negedge clock);
    mthi = 1'b0;
    check("mthi hi", 64'(hi), 64'hAAAA0001);
    check("mthi lo kept", 64'(lo), 64'h55);

    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BADF00D;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi+mtlo hi", 64'(hi), 64'h0BADF00D);
    check("mthi+mtlo lo", 64'(lo), 64'h0BADF00D);
    hi_m = 32'h0BADF00D; lo_m = 32'h0BADF00D;

    // A move in the same cycle as start is dropped.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEADBEEF;
    issue('{2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0});
    check("start beats move hi", 64'(hi), 64'h0BADF00D);
    check("start beats move lo", 64'(lo), 64'h0BADF00D);
    wait_result("start+move", 1'b0);
    @(negedge clock);

    // Reset during a divide aborts it immediately, without a done pulse.
    issue('{2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0});
    repeat (15) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    if (sb_q.size() > 0) sb_q.delete(0);
    hi_m = '0; lo_m = '0;
    @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    check("midreset no done", 64'(saw_done), 64'd0);
    v = '{2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0};
    issue(v);
    wait_result("post-reset multu", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Multi-cycle multiply/divide unit sitting directly downstream of the mips datapath's register-read/ALU stage.
- Consumes rs/rt operands issued by MULT/MULTU/DIV/DIVU, iterates one bit per cycle, and owns the HI/LO architectural registers.
- The datapath reads hi/lo for MFHI/MFLO and writes them for MTHI/MTLO.
- The datapath stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  issue operation; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  rs operand (multiplicand/dividend).
- b  input  WIDTH  rt operand (multiplier/divisor).
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress; datapath stalls.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- div_by_zero  output  1  sticky flag, set by a divide with b==0, cleared by next start.

Behaviour:
- Reset: asserting reset_n=0 forces the following immediately, regardless of clock.
  - State IDLE.
  - busy=0, done=0, hi=0, lo=0, div_by_zero=0.
  - Counter and internal accumulators cleared.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge E0 latches op, |a|, |b| and the sign info (signed ops).
  - Clears div_by_zero, loads counter=WIDTH, enters RUN; busy=1 from E0.
- RUN:
  - One iteration per edge, E1..E32 (WIDTH iterations).
  - Multiply: shift-add, 2*WIDTH-bit product accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements each edge; at counter==1 the next state is FINISH.
- FINISH (edge E33):
  - Sign fix-up applied.
  - hi/lo written.
  - done=1 for exactly one cycle.
  - busy=0.
  - Return to IDLE.
- Total latency: start edge to done = 33 cycles; back-to-back start is accepted on the cycle done is high.
- Results:
  - Multiply: {hi,lo} = full 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; remainder takes the dividend's sign.
- Boundary conditions:
  - Divide by zero (b==0): full latency still taken; hi=a (original), lo={WIDTH{1}}, div_by_zero=1 at FINISH.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0; no flag.
  - start while RUN/FINISH: ignored; operands not re-latched.
  - mthi/mtlo in IDLE with start=0: writes the register at that edge; done stays 0.
  - mthi/mtlo while busy: ignored.
  - mthi/mtlo in the same IDLE cycle as start: start wins; the move is dropped.
  - mthi and mtlo together: both written with wdata.
  - hi/lo hold their old values throughout RUN; they change only at FINISH or on a move.
  - Reset mid-RUN: aborts the operation immediately; done is never pulsed.

Optional Feature:
- Macro MIPS_MULDIV_SIGNED_EN.
- Defined: op 01/11 perform signed MULT/DIV with magnitude conversion and fix-up as above.
- Undefined:
  - op[0] is ignored; all operations are unsigned (MULT behaves as MULTU, DIV as DIVU).
  - Sign-handling logic is removed.
  - The 0x80000000/-1 rule does not apply.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 33 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21) (with MIPS_MULDIV_SIGNED_EN).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1; the next start clears the flag.
- Mid-RUN stimulus:
  - start with a new operand at cycle 10: ignored, result unchanged.
  - mthi wdata=0xAA at cycle 12: ignored.
  - After done, mtlo wdata=0x55 -> lo=0x55, no done pulse.
- reset_n low at cycle 15 of DIVU -> busy=0, hi=lo=0 immediately; no done pulse; a fresh MULTU 3*5 afterwards gives lo=15, hi=0.
